keyboard_matrix_emu: RTL
========================

// Module: keyboard_matrix_emu
// PURPOSE
//   Keyboard-side end of the POKEY key-scan interface: emulates the external key matrix.
//   Watches the scanner's key_scan_L lines and pulls kr1_L (and kr2_L for shift) low while the held key's scan code is driven.
//   Host/testbench key events enter through a valid/ready port and are buffered in a small FIFO.
//   Each key is pressed for a fixed number of full scan cycles, then released for a gap, so the scanner's debounce/compare logic sees it.
// PARAMETERS
//   SCAN_W      4   width of key_scan_L / key code (2**SCAN_W keys)
//   FIFO_DEPTH  4   key-event buffer entries (power of 2, >=2)
//   HOLD_SCANS  3   full scan cycles a key is held down (>=1)
//   GAP_SCANS   2   full scan cycles of release between keys (>=1)
//   SHIFT_SCAN  15  decoded scan value at which kr2_L reports shift
// PORTS
//   o2          in   1                    system clock, all state on posedge
//   rst_L       in   1                    async reset, active low
//   key_scan_L  in   SCAN_W               scanner column/row select, inverted (decoded = ~key_scan_L)
//   key_valid   in   1                    host offers a key event
//   key_code    in   SCAN_W               key to press (decoded scan value)
//   key_shift   in   1                    hold shift with this key
//   key_ready   out  1                    FIFO can accept (= !full)
//   kr1_L       out  1                    key return, low = key at current scan pressed
//   kr2_L       out  1                    shift return, low = shift pressed at SHIFT_SCAN
//   key_active  out  1                    a key is currently held (state PRESS)
//   fifo_count  out  $clog2(FIFO_DEPTH)+1 buffered events
// BEHAVIOUR
//   Reset (async, rst_L=0): state IDLE, FIFO empty, counters 0; kr1_L=1, kr2_L=1, key_active=0, key_ready=1, fifo_count=0.
//   Push: key_valid && key_ready at posedge -> {key_shift,key_code} written; key_valid while full is dropped, no state change.
//   Scan-complete event (scan_evt): decoded scan == 2**SCAN_W-1 this cycle and registered previous decoded scan != that value.
//   FSM:
//     IDLE    : FIFO non-empty -> pop head into cur_code/cur_shift, clear scan_cnt, go PRESS (next cycle).
//     PRESS   : key_active=1; on scan_evt scan_cnt++; scan_cnt reaches HOLD_SCANS -> clear scan_cnt, go RELEASE.
//     RELEASE : on scan_evt scan_cnt++; reaches GAP_SCANS -> IDLE. No pop in RELEASE.
//   Return lines are combinational from key_scan_L and registered state (zero latency; scanner samples same edge):
//     kr1_L = !(state==PRESS && ~key_scan_L == cur_code)
//     kr2_L = !(state==PRESS && cur_shift && ~key_scan_L == SHIFT_SCAN)
//   Entry into PRESS mid-scan: the partial scan before the first scan_evt does not count toward HOLD_SCANS.
//   Simultaneous push and pop (IDLE, non-empty, not full): both occur; fifo_count unchanged.
//   Push while empty in IDLE: pop occurs the following cycle (no write-through bypass).
//   Wrap: FIFO pointers wrap modulo FIFO_DEPTH; fifo_count saturates at FIFO_DEPTH, never overflows.
//   Scanner stalled (key_scan_L static): no scan_evt, key stays held indefinitely; not an error.
//   Reset mid-PRESS: kr1_L/kr2_L release immediately (async), buffered events discarded.
//   key_code 0 is legal; decoded 0 is the scanner's first position.
// TESTING
//   Reset: rst_L=0 mid-PRESS with code 5 held -> kr1_L=1 same cycle, fifo_count=0, key_ready=1.
//   Single key: push code 4'h6, free-running 0..15 scan -> kr1_L=0 exactly in cycles where decoded scan==6, for 3 full scans, then 1 for >=2 scans.
//   Shift: push code 4'h3 shift=1 -> kr1_L low at scan 3 and kr2_L low at scan 15, each once per scan, during PRESS only.
//   Back-to-back: push 2, 9, 12 -> pressed strictly in order, each separated by >=2 full released scans; key_active toggles 3 times.
//   Full: push 5 events with no scanning -> key_ready=0 after 4 buffered (one popped into PRESS leaves room: 5th accepted only if pop occurred); 6th dropped, count stays 4.
//   Stalled scan: hold key_scan_L=~4'h7 with code 7 pressed -> kr1_L stays 0, state stays PRESS for 1000 cycles.

Source files
------------

// File: rtl/keyboard_matrix_emu_if.sv
`default_nettype none
// ============================================================================
// Module      : keyboard_matrix_emu_if
// Description : Host/scanner-facing signal bundle of the keyboard matrix
//               emulator. The master side is the host plus scanner, the
//               slave side is the emulator itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface keyboard_matrix_emu_if #(
    parameter int SCAN_W     = 4,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [SCAN_W-1:0] key_scan_L;
    logic              key_valid;
    logic [SCAN_W-1:0] key_code;
    logic              key_shift;
    logic              key_ready;
    logic              kr1_L;
    logic              kr2_L;
    logic              key_active;
    logic [CNT_W-1:0]  fifo_count;

    modport master (
        output key_scan_L, key_valid, key_code, key_shift,
        input  key_ready, kr1_L, kr2_L, key_active, fifo_count
    );

    modport slave (
        input  key_scan_L, key_valid, key_code, key_shift,
        output key_ready, kr1_L, kr2_L, key_active, fifo_count
    );
endinterface
`default_nettype wire

// File: rtl/keyboard_matrix_emu.sv
`default_nettype none
// ============================================================================
// Module      : keyboard_matrix_emu
// Description : Keyboard-side emulation of the POKEY key matrix. Buffers key
//               events, holds each one for a number of full scan cycles and
//               answers the scanner on kr1_L / kr2_L combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module keyboard_matrix_emu #(
    parameter int SCAN_W     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int HOLD_SCANS = 3,
    parameter int GAP_SCANS  = 2,
    parameter int SHIFT_SCAN = 15
) (
    input  wire logic            o2,
    input  wire logic            rst_L,
    keyboard_matrix_emu_if.slave kb
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int HG_MAX = (HOLD_SCANS > GAP_SCANS) ? HOLD_SCANS : GAP_SCANS;
    localparam int SC_W   = $clog2(HG_MAX + 1);

    localparam logic [SCAN_W-1:0] C_SCAN_LAST = '1;
    localparam logic [SCAN_W-1:0] C_SHIFT     = SCAN_W'(SHIFT_SCAN);
    localparam logic [CNT_W-1:0]  C_FULL      = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESS   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t            state_q;
    logic [SCAN_W-1:0] cur_code_q;
    logic              cur_shift_q;
    logic [SC_W-1:0]   scan_cnt_q;
    logic              key_active_q;
    logic [SCAN_W-1:0] scan_prev_q;

    logic [SCAN_W:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;

    logic [SCAN_W-1:0] w_scan_dec;
    logic              w_scan_evt;
    logic              w_full;
    logic              w_push;
    logic              w_pop;

    assign w_scan_dec = ~kb.key_scan_L;
    // One event per pass: the first cycle the scanner sits on its last position.
    assign w_scan_evt = (w_scan_dec == C_SCAN_LAST) && (scan_prev_q != C_SCAN_LAST);
    assign w_full     = (count_q == C_FULL);
    assign w_push     = kb.key_valid && !w_full;
    assign w_pop      = (state_q == S_IDLE) && (count_q != '0);

    assign kb.key_ready  = !w_full;
    assign kb.fifo_count = count_q;
    assign kb.key_active = key_active_q;
    // Return lines follow the scan lines with no delay so the scanner samples them on the same edge.
    assign kb.kr1_L = !((state_q == S_PRESS) && (w_scan_dec == cur_code_q));
    assign kb.kr2_L = !((state_q == S_PRESS) && cur_shift_q && (w_scan_dec == C_SHIFT));

    // Occupancy moves only when exactly one of push/pop happens.
    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Event storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge o2) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {kb.key_shift, kb.key_code};
        end
    end

    // FIFO pointers and count; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge o2 or negedge rst_L) begin
        if (!rst_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Remember the previous decoded scan to detect arrival at the last position.
    always_ff @(posedge o2 or negedge rst_L) begin
        if (!rst_L) begin
            scan_prev_q <= '0;
        end else begin
            scan_prev_q <= w_scan_dec;
        end
    end

    // Press/release sequencing. In PRESS the first scan event only closes the
    // partial scan seen on entry, so HOLD_SCANS+1 events end the hold.
    always_ff @(posedge o2 or negedge rst_L) begin
        if (!rst_L) begin
            state_q      <= S_IDLE;
            cur_code_q   <= '0;
            cur_shift_q  <= 1'b0;
            scan_cnt_q   <= '0;
            key_active_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_pop) begin
                        cur_code_q   <= mem_q[rd_ptr_q][SCAN_W-1:0];
                        cur_shift_q  <= mem_q[rd_ptr_q][SCAN_W];
                        scan_cnt_q   <= '0;
                        key_active_q <= 1'b1;
                        state_q      <= S_PRESS;
                    end
                end
                S_PRESS: begin
                    if (w_scan_evt) begin
                        if (scan_cnt_q == SC_W'(HOLD_SCANS)) begin
                            scan_cnt_q   <= '0;
                            key_active_q <= 1'b0;
                            state_q      <= S_RELEASE;
                        end else begin
                            scan_cnt_q <= scan_cnt_q + SC_W'(1);
                        end
                    end
                end
                S_RELEASE: begin
                    if (w_scan_evt) begin
                        if (scan_cnt_q == SC_W'(GAP_SCANS - 1)) begin
                            scan_cnt_q <= '0;
                            state_q    <= S_IDLE;
                        end else begin
                            scan_cnt_q <= scan_cnt_q + SC_W'(1);
                        end
                    end
                end
                default: begin
                    scan_cnt_q   <= '0;
                    key_active_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
